// File: rtl/uart_rx_byte_if.sv
// uart_rx_byte_if: bundle between a serial line driver and the byte receiver.
// Signals:
//   rx_i        - serial line, idle high (driven by master)
//   data_o      - last good byte (driven by slave)
//   valid_o     - one-cycle strobe, good byte on data_o
//   frame_err_o - one-cycle strobe, stop bit sampled low
//   busy_o      - receiver not idle
interface uart_rx_byte_if #(
    parameter int DW = 8
);
    logic          rx_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          frame_err_o;
    logic          busy_o;
    modport master (output rx_i, input data_o, valid_o, frame_err_o, busy_o);
    modport slave  (input rx_i, output data_o, valid_o, frame_err_o, busy_o);
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver sampling mid-bit, LSB first, one byte per valid strobe.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - uart_rx_byte_if.slave: rx_i in; data_o, valid_o, frame_err_o, busy_o out
module uart_rx_byte #(
    parameter int BIT_TIMING   = 50000,
    parameter int UART_COUNTER = 32,
    parameter int DW           = 8
) (
    input logic           clk,
    input logic           rst,
    uart_rx_byte_if.slave bus
);
    localparam int IW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [UART_COUNTER-1:0] H_LAST = UART_COUNTER'(BIT_TIMING / 2 - 1);
    localparam logic [UART_COUNTER-1:0] N_LAST = UART_COUNTER'(BIT_TIMING - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DW - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t                  state_q, state_d;
    logic [UART_COUNTER-1:0] cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DW-1:0]           shift_q, shift_d;
    logic [DW-1:0]           data_q, data_d;
    logic                    sync1_q, rx_s_q;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    sample;

    // Half a bit into START lands mid start bit; a full bit thereafter lands mid each later bit.
    assign sample = (state_q == START) ? (cnt_q == H_LAST) :
                    (state_q == DATA || state_q == STOP) ? (cnt_q == N_LAST) : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= bus.rx_i;
            rx_s_q  <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Counter clears on every sample so it never wraps; IDLE/WAIT_HIGH hold it at zero
    // so each state entry starts counting from zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = sample ? '0 : cnt_q + UART_COUNTER'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: if (sample) begin
                state_d = rx_s_q ? IDLE : DATA;
                idx_d   = '0;
            end
            DATA: if (sample) begin
                shift_d = {rx_s_q, shift_q[DW-1:1]};
                idx_d   = idx_q + IW'(1);
                if (idx_q == IDX_LAST) state_d = STOP;
            end
            STOP: if (sample) state_d = rx_s_q ? IDLE : WAIT_HIGH;
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d = (state_q == STOP) && sample && rx_s_q;
        ferr_d  = (state_q == STOP) && sample && !rx_s_q;
        data_d  = valid_d ? shift_q : data_q;
    end

    assign bus.data_o      = data_q;
    assign bus.valid_o     = valid_q;
    assign bus.frame_err_o = ferr_q;
    assign bus.busy_o      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed UART frames checked every cycle against a timing-rule model.
module tb_uart_rx_byte;
    localparam int BT = 16;
    localparam int H  = BT / 2;
    localparam int N  = BT;
    localparam int DW = 8;

    typedef struct {
        int         mode;
        int         s;
        logic [7:0] sh;
        logic [7:0] dat;
        logic       v;
        logic       fe;
    } mst_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec = 0;
    int   mis = 0;
    int   cyc = 0;
    mst_t m = '{0, 0, 8'h00, 8'h00, 1'b0, 1'b0};
    logic r1 = 1'b1;
    logic rxs = 1'b1;
    int         vq[$];
    logic [7:0] dq[$];
    int         fq[$];

    uart_rx_byte_if #(.DW(DW)) bus ();

    uart_rx_byte #(.BIT_TIMING(BT), .UART_COUNTER(32), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s at cycle %0d: dut=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // mode 0 idle, 1 receiving (start seen at cycle s), 2 waiting for line high.
    // Samples fall at absolute cycles s+H, s+H+(k+1)N, stop at s+H+(DW+1)N.
    function automatic mst_t step(input mst_t cur, input int p, input logic x);
        mst_t n;
        int   d;
        int   k;
        n    = cur;
        n.v  = 1'b0;
        n.fe = 1'b0;
        if (cur.mode == 0) begin
            if (!x) begin
                n.mode = 1;
                n.s    = p;
            end
        end else if (cur.mode == 1) begin
            d = p - cur.s;
            if (d == H) begin
                if (x) n.mode = 0;
            end else if (d > H && (d - H) % N == 0) begin
                k = (d - H) / N - 1;
                if (k < DW) n.sh[k] = x;
                else if (x) begin
                    n.v    = 1'b1;
                    n.dat  = cur.sh;
                    n.mode = 0;
                end else begin
                    n.fe   = 1'b1;
                    n.mode = 2;
                end
            end
        end else if (x) n.mode = 0;
        return n;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m   <= '{0, 0, 8'h00, 8'h00, 1'b0, 1'b0};
            r1  <= 1'b1;
            rxs <= 1'b1;
        end else begin
            m   <= step(m, cyc, rxs);
            rxs <= r1;
            r1  <= bus.rx_i;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("cycle", {bus.valid_o, bus.frame_err_o, bus.busy_o, bus.data_o},
                  {m.v, m.fe, (m.mode != 0), m.dat});
            if (bus.valid_o) begin
                vq.push_back(cyc);
                dq.push_back(bus.data_o);
            end
            if (bus.frame_err_o) fq.push_back(cyc);
        end
    end

    task automatic clear_rec();
        vq.delete();
        dq.delete();
        fq.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.rx_i = 1'b1;
            rst      = 1'b0;
        end
    endtask

    // One 8N1 frame; rst_at >= 0 pulses reset at that offset and the sender aborts to idle.
    task automatic send(input logic [7:0] b, input int per, input int stop_len, input logic stop_v,
                        input int rst_at, output int t0);
        logic [9:0] fr;
        int         t;
        fr = {stop_v, b, 1'b0};
        t  = 0;
        t0 = 0;
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < ((j == 9) ? stop_len : per); i++) begin
                @(negedge clk);
                if (t == 0) t0 = cyc;
                if (rst_at >= 0 && t == rst_at + 1)
                    check("after_rst", {bus.valid_o, bus.frame_err_o, bus.busy_o, bus.data_o}, 32'h0);
                rst      = (t == rst_at);
                bus.rx_i = (rst_at >= 0 && t > rst_at) ? 1'b1 : fr[j];
                t++;
            end
        end
    endtask

    initial begin
        int         t0;
        int         tb0;
        logic [7:0] bb[4];
        bb       = '{8'hFE, 8'h03, 8'h04, 8'hFE};
        bus.rx_i = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.valid_o, bus.frame_err_o, bus.busy_o, bus.data_o}, 32'h0);
        idle(20);

        clear_rec();
        send(8'hFE, N, N, 1'b1, -1, t0);
        idle(20);
        check("single_count", vq.size(), 1);
        check("single_cycle", vq[0] - t0, 155);
        check("single_data", dq[0], 8'hFE);
        check("single_ferr", fq.size(), 0);

        clear_rec();
        tb0 = 0;
        for (int i = 0; i < 4; i++) begin
            send(bb[i], N, N, 1'b1, -1, t0);
            if (i == 0) tb0 = t0;
        end
        idle(20);
        check("b2b_count", vq.size(), 4);
        check("b2b_first", vq[0] - tb0, 155);
        for (int i = 0; i < 4; i++) check("b2b_data", dq[i], bb[i]);
        for (int i = 1; i < 4; i++) check("b2b_gap", vq[i] - vq[i-1], 160);

        clear_rec();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            bus.rx_i = (i < 5) ? 1'b0 : 1'b1;
            if (i == 3) check("fs_busy_high", bus.busy_o, 1);
            if (i == 11) check("fs_busy_low", bus.busy_o, 0);
        end
        check("fs_no_strobe", vq.size() + fq.size(), 0);
        send(8'h55, N, N, 1'b1, -1, t0);
        idle(20);
        check("fs_next_count", vq.size(), 1);
        check("fs_next_data", dq[0], 8'h55);

        clear_rec();
        send(8'hA5, N, 40, 1'b0, -1, t0);
        idle(40);
        check("fe_count", fq.size(), 1);
        check("fe_cycle", fq[0] - t0, 155);
        check("fe_no_valid", vq.size(), 0);
        check("fe_data_held", bus.data_o, 8'h55);
        send(8'h01, N, N, 1'b1, -1, t0);
        idle(20);
        check("fe_next_count", vq.size(), 1);
        check("fe_next_data", dq[0], 8'h01);

        clear_rec();
        send(8'h0F, N, N, 1'b1, 72, t0);
        idle(200);
        check("rst_no_strobe", vq.size() + fq.size(), 0);
        check("rst_data_zero", bus.data_o, 0);
        send(8'h05, N, N, 1'b1, -1, t0);
        idle(20);
        check("rst_next_count", vq.size(), 1);
        check("rst_next_data", dq[0], 8'h05);

        send(8'h00, 15, 15, 1'b1, -1, t0);
        idle(40);
        send(8'h00, 17, 17, 1'b1, -1, t0);
        idle(40);
        clear_rec();
        send(8'hFF, 15, 15, 1'b1, -1, t0);
        idle(40);
        check("ff15_count", vq.size(), 1);
        check("ff15_data", dq[0], 8'hFF);
        clear_rec();
        send(8'hFF, 17, 17, 1'b1, -1, t0);
        idle(40);
        check("ff17_count", vq.size(), 1);
        check("ff17_data", dq[0], 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Serial-to-byte UART receiver that sits directly upstream of the Rx frame controller. It samples the asynchronous `rx_i` line at mid-bit using a bit-period counter and assembles 8N1 characters LSB first. Each good byte is delivered as a one-cycle `valid_o` strobe with `data_o` held stable. The downstream frame controller parses the `0xFE` header/trailer and the commands `0x01/0x03/0x04/0x05` from these bytes; this block interprets no byte values.

## Interface
- `BIT_TIMING`, 50000: clock cycles per bit (50 MHz / 1000 baud); legal range ≥ 4.
- `UART_COUNTER`, 32: width of the bit-period counter.
- `DW`, 8: data bits per character.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx_i` in 1: asynchronous serial line, idle high.
- `data_o` out DW: last good byte; updates only when `valid_o` pulses; reset 0.
- `valid_o` out 1: one-cycle strobe, good byte on `data_o`; reset 0.
- `frame_err_o` out 1: one-cycle strobe, stop bit sampled low; reset 0.
- `busy_o` out 1: high in any state other than IDLE; reset 0.

## Operation
- `rx_i` passes through a 2-flop synchronizer, giving `rx_s` (reset value 1). Only `rx_s` is used internally.
- Let H = BIT_TIMING/2 (floor) and N = BIT_TIMING.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. Reset state is IDLE with the counter at 0, the bit index at 0 and the shift register at 0.
- IDLE: if `rx_s`=0, go to START and clear the counter. That cycle is s, the start-detect cycle.
- START: the counter counts to H−1, giving the sample at cycle s+H.
  - `rx_s`=0 at the sample: clear the counter, bit index = 0, go to DATA.
  - `rx_s`=1 at the sample: false start. Return to IDLE with no strobe.
- DATA: the counter counts to N−1. Bit k (k = 0..DW−1) is sampled at s+H+(k+1)N and shifted in LSB first.
  - After bit DW−1, go to STOP.
- STOP: sample at s+H+(DW+1)N.
  - `rx_s`=1: load the shift register into `data_o`, pulse `valid_o`, go to IDLE.
  - `rx_s`=0: pulse `frame_err_o`, leave `data_o` unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This prevents a break or low line from being taken as a new start.
- The counter never wraps: it is cleared on every sample event and on every state entry. UART_COUNTER must hold N−1.
- `valid_o` and `frame_err_o` are never high in the same cycle.
- `rst` asserted in any state returns all state and outputs to reset values on the next edge. A partial byte is discarded with no strobe.

## Timing
- Input latency: a change on `rx_i` reaches `rx_s` after 2 cycles.
- `valid_o` or `frame_err_o` is high exactly in cycle s+H+(DW+1)N+1 (registered), for one cycle.
- `data_o` is valid in the same cycle as `valid_o` and holds until the next good byte.
- The FSM is in IDLE in the cycle `valid_o` is high. A new start may be detected that cycle, so back-to-back characters with a full stop bit are received without loss.
- `busy_o` rises the cycle after s and falls in the cycle the strobe is high, or when WAIT_HIGH exits.
- There is no backpressure. The consumer must capture on `valid_o`; an uncaptured byte is overwritten by the next one.

## Test plan
(Simulation uses BIT_TIMING=16.)
- Single byte: send 0xFE 8N1 with an ideal line. `valid_o` pulses once for one cycle with `data_o`=0xFE, at cycle s+8+144+1; `frame_err_o` stays 0.
- Back-to-back: send 0xFE, 0x03, 0x04, 0xFE with no idle gap between stop and next start. Four `valid_o` strobes carry data 0xFE, 0x03, 0x04, 0xFE in order; consecutive strobes are exactly 160 cycles apart.
- False start: a 5-cycle low glitch on an idle line produces no strobe and `busy_o` returns to 0 by cycle s+9. A following 0x55 is then received correctly.
- Framing error: send 0xA5 with the stop bit held low for 40 cycles. `frame_err_o` pulses once and `data_o` keeps its prior value. There is no strobe until the line returns high, then a following 0x01 gives `valid_o` with 0x01.
- Reset mid-byte: assert `rst` for 1 cycle during bit 3 of 0x0F. All outputs are 0 the next cycle and no strobe occurs for that byte. A following 0x05 is received correctly.
- Extremes and bit-rate tolerance: send 0x00 and 0xFF, each with the bit period skewed to 15 and to 17 cycles. Both bytes are received correctly in all four combinations.
